capture_seq_ctrl: RTL and testbench

Sequencer for the scope sample FIFO. It drives the 3-bit fifo_state code and the write/read strobes that the FIFO read-side logic and FIFO write port consume. Each capture runs through pre-trigger fill, rolling write/read loop, post-trigger fill and SPI readout. It sits between the ADC sample path, the trigger detector and the SPI slave.

---
 rtl/capture_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_capture_seq_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/capture_seq_ctrl.sv
// Sequencer for the scope sample FIFO: pre-fill, rolling loop, post-fill, SPI readout.
// Latency: every output is registered, so a strobe follows its causing input by one cycle.
// Backpressure: fifo_full suppresses the write/pop pair and sets sticky overflow; the SPI paces readout.
// Optional build macro AUTO_TRIG_EN adds a LOOP timeout that forces the trigger.
module capture_seq_ctrl #(
  parameter int PRE_NUM      = 400,
  parameter int POST_NUM     = 400,
  parameter int CNT_W        = 11,
  parameter int AUTO_TIMEOUT = 1000000,
  parameter int TO_W         = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       arm,
  input  logic       abort,
  input  logic       trig_in,
  input  logic       adc_valid,
  input  logic       fifo_empty,
  input  logic       fifo_full,
  input  logic       spi_rd_req,
  output logic [2:0] fifo_state,
  output logic       fifo_wr_en,
  output logic       fifo_wr_flag,
  output logic       fifo_rd_flag,
  output logic       busy,
  output logic       cap_done,
  output logic       overflow,
  output logic       auto_trig
);

  // State encoding doubles as the fifo_state code seen by the read-side logic.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b111,
    ST_PRE  = 3'b011,
    ST_LOOP = 3'b001,
    ST_POST = 3'b000,
    ST_RD   = 3'b101
  } state_t;

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_NUM - 1);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_NUM - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(PRE_NUM + POST_NUM - 1);

  // Reject configurations whose counters cannot reach their terminal values.
  if (PRE_NUM + POST_NUM >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for PRE_NUM+POST_NUM");
  end
  if (AUTO_TIMEOUT >= (1 << TO_W)) begin : g_bad_to_w
    $error("TO_W too narrow for AUTO_TIMEOUT");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             arm_pend_q, arm_pend_d;
  logic             trig_q;
  logic             trig_edge;
  logic             to_hit;
  logic             wr_en_d, wr_flag_d, rd_flag_d, cap_done_d, overflow_d, auto_trig_d;

  assign trig_edge  = trig_in & ~trig_q;
  assign fifo_state = state_q;

`ifdef AUTO_TRIG_EN
  logic [TO_W-1:0] to_q;

  // Counts cycles spent in LOOP; any other state holds it at zero so each LOOP entry starts fresh.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)              to_q <= '0;
    else if (state_q != ST_LOOP) to_q <= '0;
    else                         to_q <= to_q + 1'b1;
  end

  assign to_hit = (to_q == TO_W'(AUTO_TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif

  // Next-state and next-output decode; abort overrides every other event.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    arm_pend_d  = arm_pend_q;
    wr_en_d     = 1'b0;
    wr_flag_d   = 1'b0;
    rd_flag_d   = 1'b0;
    cap_done_d  = 1'b0;
    overflow_d  = overflow;
    auto_trig_d = auto_trig;
    if (abort) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      arm_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Start only once the read side has drained the previous capture.
          if (arm_pend_q && fifo_empty) begin
            arm_pend_d  = 1'b0;
            overflow_d  = 1'b0;
            auto_trig_d = 1'b0;
            cnt_d       = '0;
            state_d     = ST_PRE;
          end else if (arm) begin
            arm_pend_d = 1'b1;
          end
        end
        ST_PRE: begin
          if (adc_valid) begin
            if (fifo_full) begin
              overflow_d = 1'b1;
            end else begin
              wr_en_d = 1'b1;
              cnt_d   = cnt_q + 1'b1;
              if (cnt_q == PRE_LAST) state_d = ST_LOOP;
            end
          end
        end
        ST_LOOP: begin
          // Paired write+pop keeps the FIFO at pre-trigger depth.
          if (adc_valid) begin
            if (fifo_full) begin
              overflow_d = 1'b1;
            end else begin
              wr_en_d   = 1'b1;
              wr_flag_d = 1'b1;
            end
          end
          if (trig_edge) begin
            state_d = ST_POST;
            cnt_d   = '0;
          end else if (to_hit) begin
            state_d     = ST_POST;
            cnt_d       = '0;
            auto_trig_d = 1'b1;
          end
        end
        ST_POST: begin
          if (adc_valid) begin
            if (fifo_full) begin
              overflow_d = 1'b1;
            end else begin
              wr_en_d = 1'b1;
              cnt_d   = cnt_q + 1'b1;
              if (cnt_q == POST_LAST) begin
                state_d = ST_RD;
                cnt_d   = '0;
              end
            end
          end
        end
        ST_RD: begin
          if (spi_rd_req) begin
            rd_flag_d = 1'b1;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == RD_LAST) begin
              cap_done_d = 1'b1;
              state_d    = ST_IDLE;
              cnt_d      = '0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      arm_pend_q   <= 1'b0;
      trig_q       <= 1'b0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_flag <= 1'b0;
      fifo_rd_flag <= 1'b0;
      busy         <= 1'b0;
      cap_done     <= 1'b0;
      overflow     <= 1'b0;
      auto_trig    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      arm_pend_q   <= arm_pend_d;
      trig_q       <= trig_in;
      fifo_wr_en   <= wr_en_d;
      fifo_wr_flag <= wr_flag_d;
      fifo_rd_flag <= rd_flag_d;
      busy         <= (state_d != ST_IDLE);
      cap_done     <= cap_done_d;
      overflow     <= overflow_d;
      auto_trig    <= auto_trig_d;
    end
  end

endmodule

// File: tb/tb_capture_seq_ctrl.sv
// Randomized bench for capture_seq_ctrl against a phase-level reference model.
// Inputs are driven and outputs sampled on the falling edge.
// Build with AUTO_TRIG_EN defined to exercise the forced-trigger path (timeout 100).
module tb_capture_seq_ctrl;

  localparam int PRE  = 400;
  localparam int POST = 400;
  localparam int TO   = 100;
  localparam int NCYC = 40000;
`ifdef AUTO_TRIG_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int P_IDLE = 0, P_PRE = 1, P_LOOP = 2, P_POST = 3, P_RD = 4;

  logic       sys_clk, sys_rst_n;
  logic       arm, abort, trig_in, adc_valid, fifo_empty, fifo_full, spi_rd_req;
  logic [2:0] fifo_state;
  logic       fifo_wr_en, fifo_wr_flag, fifo_rd_flag, busy, cap_done, overflow, auto_trig;

  capture_seq_ctrl #(
    .PRE_NUM(PRE), .POST_NUM(POST), .CNT_W(11), .AUTO_TIMEOUT(TO), .TO_W(20)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .arm(arm), .abort(abort),
    .trig_in(trig_in), .adc_valid(adc_valid), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .spi_rd_req(spi_rd_req), .fifo_state(fifo_state),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_flag(fifo_wr_flag), .fifo_rd_flag(fifo_rd_flag),
    .busy(busy), .cap_done(cap_done), .overflow(overflow), .auto_trig(auto_trig)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: which phase the capture is in and how many bytes it has moved.
  logic [2:0] code_of [5] = '{3'b111, 3'b011, 3'b001, 3'b000, 3'b101};
  int m_phase, m_bytes, m_loop_cyc, loop_target;
  bit m_pend, m_ovf, m_at, m_prev_trig;
  bit m_wr, m_flag, m_rd, m_cap;
  int m_caps = 0, m_rds = 0, m_wrs = 0;
  int d_caps = 0, d_rds = 0, d_wrs = 0;

  function automatic logic [9:0] exp_vec();
    return {code_of[m_phase], m_wr, m_flag, m_rd, (m_phase != P_IDLE), m_cap, m_ovf, m_at};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {fifo_state, fifo_wr_en, fifo_wr_flag, fifo_rd_flag, busy, cap_done, overflow, auto_trig};
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_bytes = 0; m_loop_cyc = 0;
    m_pend = 0; m_ovf = 0; m_at = 0; m_prev_trig = 0;
    m_wr = 0; m_flag = 0; m_rd = 0; m_cap = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit edge_seen;
    edge_seen   = trig_in && !m_prev_trig;
    m_prev_trig = trig_in;
    m_wr = 0; m_flag = 0; m_rd = 0; m_cap = 0;
    if (abort) begin
      m_phase = P_IDLE; m_bytes = 0; m_pend = 0; m_loop_cyc = 0;
    end else if (m_phase == P_IDLE) begin
      if (m_pend && fifo_empty) begin
        m_pend = 0; m_ovf = 0; m_at = 0; m_bytes = 0; m_phase = P_PRE;
      end else if (arm) m_pend = 1;
    end else if (m_phase == P_RD) begin
      if (spi_rd_req) begin
        m_rd = 1; m_rds++; m_bytes++;
        if (m_bytes == PRE + POST) begin
          m_cap = 1; m_caps++; m_phase = P_IDLE; m_bytes = 0;
        end
      end
    end else begin
      // PRE, LOOP and POST all write a sample when one arrives and the FIFO has room.
      if (adc_valid && fifo_full) m_ovf = 1;
      else if (adc_valid) begin
        m_wr = 1; m_wrs++;
        if (m_phase == P_LOOP) m_flag = 1;
        else m_bytes++;
      end
      if (m_phase == P_PRE && m_bytes == PRE) begin
        m_phase = P_LOOP; m_loop_cyc = 0; loop_target = $urandom_range(150);
      end else if (m_phase == P_POST && m_bytes == POST) begin
        m_phase = P_RD; m_bytes = 0;
      end else if (m_phase == P_LOOP) begin
        if (edge_seen) begin
          m_phase = P_POST; m_bytes = 0;
        end else if (AUTO && m_loop_cyc + 1 == TO) begin
          m_phase = P_POST; m_bytes = 0; m_at = 1;
        end else m_loop_cyc++;
      end
    end
  endtask

  task automatic drive_idle();
    arm = 0; abort = 0; trig_in = 0; adc_valid = 0;
    fifo_empty = 1; fifo_full = 0; spi_rd_req = 0;
  endtask

  initial begin
    bit in_reset;
    drive_idle();
    sys_rst_n = 1'b0;
    model_reset();
    loop_target = 0;
    repeat (3) @(negedge sys_clk);
    check("reset", dut_vec(), exp_vec());
    sys_rst_n = 1'b1;
    in_reset = 0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge sys_clk);
      check($sformatf("cycle%0d", cyc), dut_vec(), exp_vec());
      if (fifo_wr_en)   d_wrs++;
      if (fifo_rd_flag) d_rds++;
      if (cap_done)     d_caps++;

      if (in_reset) begin
        sys_rst_n = 1'b1;
        in_reset  = 0;
      end

      if (cyc == NCYC / 2) begin
        // Asynchronous reset in mid-flight: outputs must clear without a clock edge.
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset", dut_vec(), exp_vec());
        drive_idle();
        in_reset = 1;
      end else begin
        adc_valid  = ($urandom_range(3) != 0);
        fifo_full  = ($urandom_range(19) == 0);
        fifo_empty = (m_phase == P_IDLE) ? ($urandom_range(9) < 7) : ($urandom_range(1) == 1);
        arm        = (m_phase == P_IDLE && !m_pend) ? ($urandom_range(9) == 0)
                                                    : ($urandom_range(499) == 0);
        if (m_phase == P_LOOP)
          trig_in = (m_loop_cyc >= loop_target) && (((m_loop_cyc - loop_target) % 4) < 2);
        else
          trig_in = ($urandom_range(49) == 0);
        spi_rd_req = (m_phase == P_RD) ? ($urandom_range(4) < 2) : ($urandom_range(49) == 0);
        abort      = ($urandom_range(2999) == 0);
        model_step();
      end
    end

    check("wr_en_total", d_wrs, m_wrs);
    check("rd_flag_total", d_rds, m_rds);
    check("cap_done_total", d_caps, m_caps);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
